// File: rtl/coproc_seq.sv
// CV-X-IF offload sequencer: accepts custom opcodes 0x08/0x09/0x0A into an in-order table,
// applies core commit/kill, and runs committed entries one at a time through the execution unit.
module coproc_seq #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]       issue_rs0_i,
  input  logic [XLEN-1:0]       issue_rs1_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  exec_valid_o,
  input  logic                  exec_ready_i,
  output logic [6:0]            exec_op_o,
  output logic [XLEN-1:0]       exec_rs0_o,
  output logic [XLEN-1:0]       exec_rs1_o,
  input  logic                  exec_done_i,
  input  logic [XLEN-1:0]       exec_data_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]       result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o,
  output logic                  busy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [6:0] OP_RMLD = 7'h08;
  localparam logic [6:0] OP_RMST = 7'h09;
  localparam logic [6:0] OP_TEST = 7'h0A;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_RESULT} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH-1:0]        valid_q, valid_d, cmt_q, cmt_d, kill_q, kill_d;
  logic [DEPTH-1:0]        id_match, commit_hit;
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [X_ID_WIDTH-1:0]   id_q  [DEPTH];
  logic [6:0]              op_q  [DEPTH];
  logic [4:0]              rd_q  [DEPTH];
  logic [XLEN-1:0]         rs0_q [DEPTH];
  logic [XLEN-1:0]         rs1_q [DEPTH];
  logic                    wb_q  [DEPTH];

  logic [6:0]              exec_op_q, exec_op_d;
  logic [XLEN-1:0]         exec_rs0_q, exec_rs0_d, exec_rs1_q, exec_rs1_d;
  logic [X_ID_WIDTH-1:0]   result_id_q, result_id_d;
  logic [XLEN-1:0]         result_data_q, result_data_d;
  logic [4:0]              result_rd_q, result_rd_d;

  logic [6:0]              issue_op;
  logic                    op_known, id_hit, full, push, pop, commit_new;
  logic                    head_empty, head_killed, head_commit_now;
  logic [6:0]              head_op;
  logic [XLEN-1:0]         head_rs0, head_rs1;
  logic                    unused_instr_bits;

  assign unused_instr_bits = ^issue_instr_i[31:12];

  assign issue_op          = issue_instr_i[6:0];
  assign op_known          = issue_op inside {OP_RMLD, OP_RMST, OP_TEST};
  assign issue_accept_o    = issue_valid_i && op_known;
  assign issue_writeback_o = issue_accept_o && (issue_op != OP_RMST);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign id_match[gi]   = valid_q[gi] && (id_q[gi] == issue_id_i);
    assign commit_hit[gi] = commit_valid_i && valid_q[gi] && !cmt_q[gi] && !kill_q[gi]
                            && (id_q[gi] == commit_id_i);
  end

  assign id_hit        = |id_match;
  assign full          = (count_q == CNT_W'(DEPTH));
  assign issue_ready_o = rst_ni && !full && !id_hit
                         && (!issue_accept_o || issue_rs_valid_i == 2'b11);
  assign push          = issue_valid_i && issue_ready_o && issue_accept_o;
  assign commit_new    = push && commit_valid_i && (commit_id_i == issue_id_i);

  // With an empty table the entry being enqueued is the head, so a same-cycle
  // commit can start dispatch without waiting for the table write.
  assign head_empty      = (count_q == '0);
  assign head_op         = head_empty ? issue_op    : op_q[head_q];
  assign head_rs0        = head_empty ? issue_rs0_i : rs0_q[head_q];
  assign head_rs1        = head_empty ? issue_rs1_i : rs1_q[head_q];
  assign head_killed     = !head_empty && kill_q[head_q];
  assign head_commit_now = head_empty ? (commit_new && !commit_kill_i)
                                      : (cmt_q[head_q] || (commit_hit[head_q] && !commit_kill_i));

  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_q;
    kill_d  = kill_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_hit[i]) begin
        if (commit_kill_i) kill_d[i] = 1'b1;
        else               cmt_d[i]  = 1'b1;
      end
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      cmt_d[tail_q]   = commit_new && !commit_kill_i;
      kill_d[tail_q]  = commit_new && commit_kill_i;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      cmt_d[head_q]   = 1'b0;
      kill_d[head_q]  = 1'b0;
    end
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    exec_op_d     = exec_op_q;
    exec_rs0_d    = exec_rs0_q;
    exec_rs1_d    = exec_rs1_q;
    result_id_d   = result_id_q;
    result_data_d = result_data_q;
    result_rd_d   = result_rd_q;
    case (state_q)
      S_IDLE: begin
        if (head_killed) begin
          pop = 1'b1;
        end else if (head_commit_now) begin
          exec_op_d  = head_op;
          exec_rs0_d = head_rs0;
          exec_rs1_d = head_rs1;
          state_d    = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (exec_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done_i) begin
          if (wb_q[head_q]) begin
            result_id_d   = id_q[head_q];
            result_rd_d   = rd_q[head_q];
            result_data_d = exec_data_i;
            state_d       = S_RESULT;
          end else begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RESULT: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      cmt_q         <= '0;
      kill_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      exec_op_q     <= '0;
      exec_rs0_q    <= '0;
      exec_rs1_q    <= '0;
      result_id_q   <= '0;
      result_data_q <= '0;
      result_rd_q   <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      cmt_q         <= cmt_d;
      kill_q        <= kill_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      exec_op_q     <= exec_op_d;
      exec_rs0_q    <= exec_rs0_d;
      exec_rs1_q    <= exec_rs1_d;
      result_id_q   <= result_id_d;
      result_data_q <= result_data_d;
      result_rd_q   <= result_rd_d;
    end
  end

  // Payload needs no reset: an entry is only read while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[tail_q]  <= issue_id_i;
      op_q[tail_q]  <= issue_op;
      rd_q[tail_q]  <= issue_instr_i[11:7];
      rs0_q[tail_q] <= issue_rs0_i;
      rs1_q[tail_q] <= issue_rs1_i;
      wb_q[tail_q]  <= issue_writeback_o;
    end
  end

  assign exec_valid_o   = (state_q == S_DISPATCH);
  assign exec_op_o      = exec_op_q;
  assign exec_rs0_o     = exec_rs0_q;
  assign exec_rs1_o     = exec_rs1_q;
  assign result_valid_o = (state_q == S_RESULT);
  assign result_we_o    = (state_q == S_RESULT);
  assign result_id_o    = result_id_q;
  assign result_data_o  = result_data_q;
  assign result_rd_o    = result_rd_q;
  assign busy_o         = (count_q != '0) || (state_q != S_IDLE);

endmodule
